// File: rtl/fcmp_flag_wait_pkg.sv
// Shared types and constants for the FP-compare flag consumer: jump-type codes,
// flag bit positions and the wait-queue entry payload.
package fcmp_flag_wait_pkg;

    localparam logic [4:0] JT_EQ  = 5'd0;
    localparam logic [4:0] JT_NE  = 5'd1;
    localparam logic [4:0] JT_LT  = 5'd2;
    localparam logic [4:0] JT_GE  = 5'd3;
    localparam logic [4:0] JT_LE  = 5'd4;
    localparam logic [4:0] JT_GT  = 5'd5;
    localparam logic [4:0] JT_UN  = 5'd6;
    localparam logic [4:0] JT_ORD = 5'd7;
    localparam logic [4:0] JT_ULT = 5'd8;
    localparam logic [4:0] JT_UGE = 5'd9;
    localparam logic [4:0] JT_ULE = 5'd10;
    localparam logic [4:0] JT_UGT = 5'd11;
    localparam logic [4:0] JT_UEQ = 5'd12;
    localparam logic [4:0] JT_ONE = 5'd13;
    localparam logic [4:0] JT_ALW = 5'd14;
    localparam logic [4:0] JT_NEV = 5'd15;

    localparam int FL_NC = 5;
    localparam int FL_UN = 4;
    localparam int FL_S  = 2;
    localparam int FL_Z  = 1;
    localparam int FL_P  = 0;

    // Tag and id live in their own arrays because their widths are module parameters.
    typedef struct packed {
        logic [4:0] jtype;
        logic       rdy;
        logic [5:0] flags;
    } qent_t;

    function automatic logic jtype_reserved(input logic [4:0] jt);
        return jt[4];
    endfunction

endpackage

// File: rtl/fcmp_flag_wait_if.sv
// Flag-write, branch-request and branch-result signals between the fcmp pipeline,
// the branch issue side and the resolution unit.
interface fcmp_flag_wait_if #(
    parameter int TAG_W = 3,
    parameter int ID_W  = 6
) ();
    logic             fl_alloc;
    logic [TAG_W-1:0] fl_atag;
    logic             fl_wen;
    logic [TAG_W-1:0] fl_wtag;
    logic [5:0]       fl_wdata;
    logic             br_valid;
    logic             br_ready;
    logic [TAG_W-1:0] br_tag;
    logic [4:0]       br_jtype;
    logic [ID_W-1:0]  br_id;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic             res_taken;
    logic             res_illeg;
    logic             flush;

    modport master (
        output fl_alloc, fl_atag, fl_wen, fl_wtag, fl_wdata,
        output br_valid, br_tag, br_jtype, br_id, res_ready, flush,
        input  br_ready, res_valid, res_id, res_taken, res_illeg
    );

    modport slave (
        input  fl_alloc, fl_atag, fl_wen, fl_wtag, fl_wdata,
        input  br_valid, br_tag, br_jtype, br_id, res_ready, flush,
        output br_ready, res_valid, res_id, res_taken, res_illeg
    );
endinterface

// File: rtl/fcmp_flag_wait_fcond_eval.sv
// Combinational condition evaluator: fcmp flags plus 5-bit jump type to taken/illegal.
// Shared with the integer branch path, so it carries no state.
module fcond_eval
    import fcmp_flag_wait_pkg::*;
(
    input  logic [5:0] flags,
    input  logic [4:0] jtype,
    output logic       taken,
    output logic       illeg
);
    logic nc, s, z, p;
    logic unused_flags;

    assign nc = flags[FL_NC];
    assign s  = flags[FL_S];
    assign z  = flags[FL_Z];
    assign p  = flags[FL_P];
    // UN duplicates P and bit 3 is always zero; neither feeds a condition.
    assign unused_flags = flags[FL_UN] ^ flags[3];

    always_comb begin
        taken = 1'b0;
        illeg = 1'b0;
        if (jtype_reserved(jtype)) begin
            illeg = 1'b1;
        end else begin
            case (jtype)
                JT_EQ:   taken = z & ~p;
                JT_NE:   taken = ~z | p;
                JT_LT:   taken = s & ~p;
                JT_GE:   taken = ~s & ~p;
                JT_LE:   taken = (s | z) & ~p;
                JT_GT:   taken = ~s & ~z & ~p;
                JT_UN:   taken = p;
                JT_ORD:  taken = ~p;
                JT_ULT:  taken = ~nc;
                JT_UGE:  taken = nc;
                JT_ULE:  taken = ~nc | z;
                JT_UGT:  taken = nc & ~z;
                JT_UEQ:  taken = z | p;
                JT_ONE:  taken = ~z & ~p;
                JT_ALW:  taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/fcmp_flag_wait.sv
// Flag tag table plus in-order branch wait queue; each branch resolves once its flag tag
// is ready. State changes on the falling edge to line up with the fcmp result registers.
module fcmp_flag_wait
    import fcmp_flag_wait_pkg::*;
#(
    parameter int TAG_W = 3,
    parameter int DEPTH = 4,
    parameter int ID_W  = 6
) (
    input logic              clk,
    input logic              rst,
    fcmp_flag_wait_if.slave  bus
);
    localparam int NTAG = 1 << TAG_W;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;

    logic             tbl_rdy_q   [NTAG];
    logic             tbl_rdy_d   [NTAG];
    logic [5:0]       tbl_flags_q [NTAG];
    logic [5:0]       tbl_flags_d [NTAG];

    logic [TAG_W-1:0] q_tag_q [DEPTH];
    logic [TAG_W-1:0] q_tag_d [DEPTH];
    logic [ID_W-1:0]  q_id_q  [DEPTH];
    logic [ID_W-1:0]  q_id_d  [DEPTH];
    qent_t            q_ent_q [DEPTH];
    qent_t            q_ent_d [DEPTH];

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic             res_taken_q, res_taken_d;
    logic             res_illeg_q, res_illeg_d;

    logic [AW-1:0]    head_idx, tail_idx;
    logic             full, empty, push, pop, out_free, bypass;
    qent_t            new_ent, head_ent;
    logic             eval_taken, eval_illeg;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
    assign empty    = (head_q == tail_q);
    assign bus.br_ready = ~full;

    assign head_ent = q_ent_q[head_idx];
    assign out_free = ~res_valid_q | bus.res_ready;
    assign push     = bus.br_valid & ~full & ~bus.flush;
    assign pop      = ~empty & head_ent.rdy & out_free & ~bus.flush;

    // A write landing on the branch's tag in the accept cycle supersedes the table copy.
    assign bypass        = bus.fl_wen && (bus.fl_wtag == bus.br_tag);
    assign new_ent.jtype = bus.br_jtype;
    assign new_ent.rdy   = bypass | tbl_rdy_q[bus.br_tag];
    assign new_ent.flags = bypass ? bus.fl_wdata : tbl_flags_q[bus.br_tag];

    fcond_eval u_eval (
        .flags (head_ent.flags),
        .jtype (head_ent.jtype),
        .taken (eval_taken),
        .illeg (eval_illeg)
    );

    always_comb begin
        for (int t = 0; t < NTAG; t++) begin
            tbl_rdy_d[t]   = tbl_rdy_q[t];
            tbl_flags_d[t] = tbl_flags_q[t];
            // A same-cycle write to a freshly allocated tag came from the old producer.
            if (bus.fl_alloc && (bus.fl_atag == TAG_W'(t))) begin
                tbl_rdy_d[t] = 1'b0;
            end else if (bus.fl_wen && (bus.fl_wtag == TAG_W'(t))) begin
                tbl_rdy_d[t]   = 1'b1;
                tbl_flags_d[t] = bus.fl_wdata;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_tag_d[i] = q_tag_q[i];
            q_id_d[i]  = q_id_q[i];
            q_ent_d[i] = q_ent_q[i];
            if (bus.fl_wen && !q_ent_q[i].rdy && (q_tag_q[i] == bus.fl_wtag)) begin
                q_ent_d[i].rdy   = 1'b1;
                q_ent_d[i].flags = bus.fl_wdata;
            end
            if (push && (tail_idx == AW'(i))) begin
                q_tag_d[i] = bus.br_tag;
                q_id_d[i]  = bus.br_id;
                q_ent_d[i] = new_ent;
            end
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_taken_d = res_taken_q;
        res_illeg_d = res_illeg_q;
        if (bus.flush) begin
            head_d      = tail_q;
            res_valid_d = 1'b0;
        end else begin
            if (pop) begin
                head_d      = head_q + PW'(1);
                res_valid_d = 1'b1;
                res_id_d    = q_id_q[head_idx];
                res_taken_d = eval_taken;
                res_illeg_d = eval_illeg;
            end else if (bus.res_ready) begin
                res_valid_d = 1'b0;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTAG; t++) begin
                tbl_rdy_q[t]   <= 1'b1;
                tbl_flags_q[t] <= 6'd0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                q_tag_q[i] <= '0;
                q_id_q[i]  <= '0;
                q_ent_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_taken_q <= 1'b0;
            res_illeg_q <= 1'b0;
        end else begin
            for (int t = 0; t < NTAG; t++) begin
                tbl_rdy_q[t]   <= tbl_rdy_d[t];
                tbl_flags_q[t] <= tbl_flags_d[t];
            end
            for (int i = 0; i < DEPTH; i++) begin
                q_tag_q[i] <= q_tag_d[i];
                q_id_q[i]  <= q_id_d[i];
                q_ent_q[i] <= q_ent_d[i];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_taken_q <= res_taken_d;
            res_illeg_q <= res_illeg_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_taken = res_taken_q;
    assign bus.res_illeg = res_illeg_q;

endmodule
